// File: rtl/reg_file_mp.sv
// Multi-port register file with a write-pending scoreboard.
// Ports: clk, Reset (sync, active-high); write ports WE3/A3/WD3 (wins on
// address conflicts) and WE4/A4/WD4; packed read ports RA/RD; R15 holds the
// PC+8 value; Claim/ClaimAddr mark a register as pending; Busy is per read
// port and Stall is the OR of Busy. Define REGFILE_BYPASS_EN to make reads
// write-first; by default reads return the pre-write value.
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     WE3,
  input  logic [3:0]               A3,
  input  logic [DATA_W-1:0]        WD3,
  input  logic                     WE4,
  input  logic [3:0]               A4,
  input  logic [DATA_W-1:0]        WD4,
  input  logic [NUM_RD*4-1:0]      RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  input  logic [DATA_W-1:0]        R15,
  input  logic                     Claim,
  input  logic [3:0]               ClaimAddr,
  output logic [NUM_RD-1:0]        Busy,
  output logic                     Stall
);

  localparam logic [3:0] PC_ADDR = 4'hF;

  logic [DATA_W-1:0] regs [15];
  logic [14:0]       busy;
  logic              wr3;
  logic              wr4;
  logic              clm;

  assign wr3 = WE3 && (A3 != PC_ADDR);
  assign wr4 = WE4 && (A4 != PC_ADDR);
  assign clm = Claim && (ClaimAddr != PC_ADDR);

  // WE3 is applied last so it overrides WE4 on the same address.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (wr4) regs[A4] <= WD4;
      if (wr3) regs[A3] <= WD3;
    end
  end

  // A claim is applied after the write clears, so it wins on a collision.
  always_ff @(posedge clk) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      if (wr4) busy[A4] <= 1'b0;
      if (wr3) busy[A3] <= 1'b0;
      if (clm) busy[ClaimAddr] <= 1'b1;
    end
  end

  always_comb begin
    RD   = '0;
    Busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (RA[4*k +: 4] == PC_ADDR) begin
        RD[DATA_W*k +: DATA_W] = R15;
`ifdef REGFILE_BYPASS_EN
      end else if (wr3 && (A3 == RA[4*k +: 4])) begin
        RD[DATA_W*k +: DATA_W] = WD3;
      end else if (wr4 && (A4 == RA[4*k +: 4])) begin
        RD[DATA_W*k +: DATA_W] = WD4;
`endif
      end else begin
        RD[DATA_W*k +: DATA_W] = regs[RA[4*k +: 4]];
      end
      // An in-flight write to the register satisfies the pending claim.
      Busy[k] = (RA[4*k +: 4] != PC_ADDR)
             && busy[RA[4*k +: 4]]
             && !(wr3 && (A3 == RA[4*k +: 4]))
             && !(wr4 && (A4 == RA[4*k +: 4]));
    end
  end

  assign Stall = |Busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: directed vectors, expected values queued
// by the stimulus and checked by an independent monitor each negedge.
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        WE3, WE4, Claim;
  logic [3:0]  A3, A4, ClaimAddr;
  logic [31:0] WD3, WD4, R15;
  logic [11:0] RA;
  logic [95:0] RD;
  logic [2:0]  Busy;
  logic        Stall;

  reg_file_mp #(.DATA_W(32), .NUM_RD(3)) dut (
    .clk(clk), .Reset(Reset),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .WE4(WE4), .A4(A4), .WD4(WD4),
    .RA(RA), .RD(RD), .R15(R15),
    .Claim(Claim), .ClaimAddr(ClaimAddr),
    .Busy(Busy), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] rd;
    logic [2:0]  busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic expect_rd(input string n, input int p,
                           input logic [31:0] d, input logic [2:0] b);
    exp_t e;
    e.name = n; e.port = p; e.rd = d; e.busy = b;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    Reset = 1'b0;
    WE3 = 1'b0; WE4 = 1'b0; Claim = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (RD[e.port*32 +: 32] !== e.rd || Busy !== e.busy
          || Stall !== (|e.busy)) begin
        $display("FAIL %s: port%0d rd=%h busy=%b stall=%b, want rd=%h busy=%b stall=%b",
                 e.name, e.port, RD[e.port*32 +: 32], Busy, Stall,
                 e.rd, e.busy, |e.busy);
      end else begin
        passed++;
      end
    end
  end

  initial begin
    Reset = 1'b1;
    WE3 = 1'b1; A3 = 4'd1; WD3 = 32'hFF;
    WE4 = 1'b0; A4 = 4'd0; WD4 = '0;
    Claim = 1'b1; ClaimAddr = 4'd1;
    R15 = 32'h0000_1008;
    RA = '0;

    for (int a = 0; a < 16; a++) begin
      tick();
      RA = {a[3:0], a[3:0], a[3:0]};
      for (int p = 0; p < 3; p++)
        expect_rd("reset_sweep", p, (a == 15) ? 32'h0000_1008 : 32'h0, 3'b000);
    end

    tick();
    WE3 = 1; A3 = 5; WD3 = 32'hDEAD_BEEF;
    WE4 = 1; A4 = 5; WD4 = 32'h1234_5678;
    RA = {4'd0, 4'd0, 4'd5};
    expect_rd("dual_wr_same_cycle", 0, BYP ? 32'hDEAD_BEEF : 32'h0, 3'b000);
    tick();
    RA = {4'd0, 4'd0, 4'd5};
    expect_rd("we3_priority", 0, 32'hDEAD_BEEF, 3'b000);

    tick();
    R15 = 32'h40;
    WE3 = 1; A3 = 15; WD3 = 32'hFFFF_FFFF;
    WE4 = 1; A4 = 15; WD4 = 32'hEEEE_EEEE;
    RA = {4'd0, 4'd5, 4'd15};
    expect_rd("r15_read", 0, 32'h40, 3'b000);
    tick();
    RA = {4'd14, 4'd5, 4'd0};
    expect_rd("r15_wr_discard_r0", 0, 32'h0, 3'b000);
    expect_rd("r15_wr_discard_r5", 1, 32'hDEAD_BEEF, 3'b000);
    expect_rd("r15_wr_discard_r14", 2, 32'h0, 3'b000);

    tick();
    WE3 = 1; A3 = 1; WD3 = 32'h1111_1111;
    WE4 = 1; A4 = 2; WD4 = 32'h2222_2222;
    tick();
    RA = {4'd0, 4'd2, 4'd1};
    expect_rd("dual_wr_r1", 0, 32'h1111_1111, 3'b000);
    expect_rd("dual_wr_r2", 1, 32'h2222_2222, 3'b000);
    expect_rd("dual_wr_r0", 2, 32'h0, 3'b000);

    tick();
    Claim = 1; ClaimAddr = 7;
    RA = {4'd7, 4'd7, 4'd7};
    expect_rd("claim_not_yet", 1, 32'h0, 3'b000);
    tick();
    RA = {4'd0, 4'd7, 4'd0};
    expect_rd("claim_busy", 1, 32'h0, 3'b010);
    tick();
    WE3 = 1; A3 = 7; WD3 = 32'h77;
    RA = {4'd0, 4'd7, 4'd0};
    expect_rd("busy_wr_now", 1, BYP ? 32'h77 : 32'h0, 3'b000);
    tick();
    RA = {4'd7, 4'd7, 4'd0};
    expect_rd("busy_cleared_p1", 1, 32'h77, 3'b000);
    expect_rd("busy_cleared_p2", 2, 32'h77, 3'b000);

    tick();
    Claim = 1; ClaimAddr = 3;
    WE4 = 1; A4 = 3; WD4 = 32'h33;
    tick();
    RA = {4'd0, 4'd3, 4'd3};
    expect_rd("claim_wins", 0, 32'h33, 3'b011);
    tick();
    WE4 = 1; A4 = 3; WD4 = 32'h34;
    RA = {4'd0, 4'd3, 4'd3};
    expect_rd("we4_wr_now", 0, BYP ? 32'h34 : 32'h33, 3'b000);
    tick();
    RA = {4'd0, 4'd0, 4'd3};
    expect_rd("we4_cleared", 0, 32'h34, 3'b000);

    tick();
    Claim = 1; ClaimAddr = 15;
    tick();
    RA = {4'd15, 4'd15, 4'd15};
    expect_rd("claim15_ignored", 0, 32'h40, 3'b000);

    tick();
    WE3 = 1; A3 = 2; WD3 = 32'hA5A5_A5A5;
    RA = {4'd0, 4'd0, 4'd2};
    expect_rd("bypass_we3", 0, BYP ? 32'hA5A5_A5A5 : 32'h2222_2222, 3'b000);
    tick();
    WE4 = 1; A4 = 9; WD4 = 32'h99;
    RA = {4'd0, 4'd0, 4'd9};
    expect_rd("bypass_we4", 0, BYP ? 32'h99 : 32'h0, 3'b000);
    tick();
    RA = {4'd0, 4'd9, 4'd2};
    expect_rd("after_bypass_r2", 0, 32'hA5A5_A5A5, 3'b000);
    expect_rd("after_bypass_r9", 1, 32'h99, 3'b000);

    tick();
    Claim = 1; ClaimAddr = 4;
    tick();
    Reset = 1;
    WE3 = 1; A3 = 6; WD3 = 32'h66;
    Claim = 1; ClaimAddr = 8;
    RA = {4'd6, 4'd8, 4'd4};
    expect_rd("pre_reset_busy", 0, 32'h0, 3'b001);
    tick();
    RA = {4'd6, 4'd8, 4'd4};
    expect_rd("post_reset_r4", 0, 32'h0, 3'b000);
    expect_rd("post_reset_r8", 1, 32'h0, 3'b000);
    expect_rd("post_reset_r6", 2, 32'h0, 3'b000);
    tick();
    RA = {4'd15, 4'd2, 4'd5};
    expect_rd("post_reset_r5", 0, 32'h0, 3'b000);
    expect_rd("post_reset_r2", 1, 32'h0, 3'b000);
    expect_rd("post_reset_r15", 2, 32'h40, 3'b000);

    tick();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0)
      $display("FAIL drain: %0d entries left, want 0", q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, width of each register and data port.
REQ-002 Parameter NUM_RD, default 3, number of read ports (legal 1..4).
REQ-003 Parameter R15 address fixed at 4'hF; ADDR_W fixed at 4, giving 15 storage registers R0..R14.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 WE3, A3[3:0], WD3[DATA_W-1:0]  input  primary write port (ALU/load result).
REQ-007 WE4, A4[3:0], WD4[DATA_W-1:0]  input  secondary write port (base writeback).
REQ-008 RA  input  NUM_RD*4  packed read addresses; port k = RA[4k+3:4k].
REQ-009 RD  output  NUM_RD*DATA_W  packed read data; port k = RD[DATA_W*k+DATA_W-1:DATA_W*k].
REQ-010 R15  input  DATA_W  current PC+8 value supplied by datapath.
REQ-011 Claim, ClaimAddr[3:0]  input  scoreboard: marks a register as pending a write.
REQ-012 Busy  output  NUM_RD  per-read-port pending flag.
REQ-013 Stall  output  1  OR of all Busy bits.

Function
REQ-014 Read port k with address 15 SHALL return R15 combinationally, never storage.
REQ-015 Read port k with address 0..14 SHALL return stored register combinationally, zero cycles latency.
REQ-016 Writes SHALL occur at posedge when WEn=1 and An!=15; writes to address 15 SHALL be silently discarded.
REQ-017 WE3 and WE4 to same address in same cycle: WD3 SHALL be stored, WD4 discarded.
REQ-018 WE3 and WE4 to different addresses SHALL both be stored in the same cycle.
REQ-019 Scoreboard holds 15 busy bits; Claim=1 with ClaimAddr!=15 SHALL set busy[ClaimAddr] at next posedge.
REQ-020 A write (either port, WEn=1, An!=15) SHALL clear busy[An] at next posedge.
REQ-021 Claim and write to same address in same cycle: busy SHALL end set (claim wins).
REQ-022 Claim to address 15 SHALL be ignored; busy for 15 is constant 0.
REQ-023 Busy[k] SHALL be 1 when busy[RA_k] is set and RA_k is not being written this cycle by WE3 or WE4; otherwise 0.
REQ-024 Stall SHALL equal |Busy, combinational.

Reset
REQ-025 Reset=1 at posedge SHALL clear R0..R14 to 0 and all busy bits to 0, overriding any write or claim in that cycle.
REQ-026 After reset, RD port k SHALL read 0 for addresses 0..14 and R15 for address 15; Busy and Stall SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL drop all pending claims; no write is lost or applied in the reset cycle.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: a read of address A (0..14) in the same cycle as a write to A SHALL return the write data (WD3 priority over WD4), i.e. write-first.
REQ-029 REGFILE_BYPASS_EN undefined: reads SHALL return stored (pre-write) data; the written value is visible the cycle after; Busy rule REQ-023 unchanged.

Verification
REQ-030 Reset, then read all ports at A=0..14 with R15=32'h0000_1008 -> RD=0 for 0..14, RD=32'h0000_1008 at A=15, Stall=0.
REQ-031 WE3=1,A3=5,WD3=32'hDEAD_BEEF; WE4=1,A4=5,WD4=32'h1234_5678 -> next cycle RA0=5 reads 32'hDEAD_BEEF.
REQ-032 WE3=1,A3=15,WD3=32'hFFFF_FFFF; R15=32'h40 -> RA0=15 reads 32'h40; no storage changes.
REQ-033 Claim A=7; next cycle RA1=7 -> Busy[1]=1, Stall=1; then WE3 A3=7 -> Busy[1]=0 same cycle, busy cleared next cycle.
REQ-034 Claim A=3 and WE4 A4=3 same cycle -> next cycle Busy for RA=3 is 1.
REQ-035 WE3 A3=2 WD3=32'hA5A5_A5A5 with RA0=2 same cycle -> RD0=32'hA5A5_A5A5 with REGFILE_BYPASS_EN, old value without.
